// File: rtl/frogger_hazard_ctrl_pkg.sv
// Shared constants for the frogger hazard controller: tile codes, row map,
// initial lane occupancy and the per-row rotation rule.
package frogger_pkg;

   localparam logic [3:0] TILE_ROAD  = 4'd0;
   localparam logic [3:0] TILE_CAR   = 4'd1;
   localparam logic [3:0] TILE_WATER = 4'd2;
   localparam logic [3:0] TILE_LOG   = 4'd3;
   localparam logic [3:0] TILE_LILY  = 4'd4;
   localparam logic [3:0] TILE_GRASS = 4'd5;

   localparam logic [5:0] GOAL_ROW    = 6'd0;
   localparam logic [5:0] RIVER_FIRST = 6'd1;
   localparam logic [5:0] RIVER_LAST  = 6'd6;
   localparam logic [5:0] MEDIAN_ROW  = 6'd7;
   localparam logic [5:0] ROAD_FIRST  = 6'd8;
   localparam logic [5:0] ROAD_LAST   = 6'd13;
   localparam logic [5:0] START_ROW   = 6'd14;
   localparam logic [5:0] NUM_COLS    = 6'd14;

   localparam logic [13:0] LILY_MASK = 14'b10010010010010;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} hz_state_e;

   // Bit c of a pattern is column c; row 7 has a slot but is never displayed.
   function automatic logic [13:0] lane_init(input logic [3:0] row);
      case (row)
         4'd1:    lane_init = 14'b11100011100011;
         4'd2:    lane_init = 14'b00111100001111;
         4'd3:    lane_init = 14'b11110000111100;
         4'd4:    lane_init = 14'b01110011100111;
         4'd5:    lane_init = 14'b11000111100011;
         4'd6:    lane_init = 14'b00011110001111;
         4'd8:    lane_init = 14'b00000000000011;
         4'd9:    lane_init = 14'b00000000000011;
         4'd10:   lane_init = 14'b00110000110000;
         4'd11:   lane_init = 14'b01100000011000;
         4'd12:   lane_init = 14'b00001100000110;
         4'd13:   lane_init = 14'b11000000110000;
         default: lane_init = 14'b0;
      endcase
   endfunction

   function automatic logic [13:0] rot_lane(input logic [3:0] row, input logic [13:0] p);
      rot_lane = row[0] ? {p[0], p[13:1]} : {p[12:0], p[13]};
   endfunction

endpackage

// File: rtl/frogger_hazard_ctrl_if.sv
// Game-side signal bundle of the hazard controller; the controller is the slave.
interface frogger_hazard_ctrl_if;
   logic       i_Game_Active;
   logic [6:0] i_Score;
   logic [5:0] i_Frogger_X;
   logic [5:0] i_Frogger_Y;
   logic [5:0] i_Query_Col;
   logic [5:0] i_Query_Row;
   logic [3:0] o_Tile;
   logic       o_Collided;
   logic       o_Lane_Tick;

   modport slave (
      input  i_Game_Active, i_Score, i_Frogger_X, i_Frogger_Y, i_Query_Col, i_Query_Row,
      output o_Tile, o_Collided, o_Lane_Tick
   );

   modport master (
      output i_Game_Active, i_Score, i_Frogger_X, i_Frogger_Y, i_Query_Col, i_Query_Row,
      input  o_Tile, o_Collided, o_Lane_Tick
   );
endinterface

// File: rtl/frogger_hazard_ctrl_lane_tick_gen.sv
// Score-dependent lane-shift timer: saturated period, free-running count and
// a strobe that tells the lane store to rotate on this edge.
module lane_tick_gen #(
   parameter int unsigned c_TICK_BASE = 25000000,
   parameter int unsigned c_TICK_STEP = 150000,
   parameter int unsigned c_TICK_MIN  = 5000000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [6:0] score_i,
   output logic       tick_o,
   output logic       lane_tick_o
);

   logic [31:0] step_prod;
   logic [31:0] period;
   logic [31:0] cnt_q, cnt_d;
   logic        tick_q;

   always_comb begin
      step_prod = 32'(score_i) * 32'(c_TICK_STEP);
      if (step_prod > 32'(c_TICK_BASE)) begin
         period = 32'(c_TICK_MIN);
      end else begin
         period = 32'(c_TICK_BASE) - step_prod;
         if (period < 32'(c_TICK_MIN)) period = 32'(c_TICK_MIN);
      end
   end

   // >= rather than == so a lowered period mid-count fires on the next clock.
   assign tick_o = en_i && (cnt_q >= period - 32'd1);

   always_comb begin
      cnt_d = cnt_q + 32'd1;
      if (!en_i || tick_o) cnt_d = 32'd0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= 32'd0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_o;
      end
   end

   assign lane_tick_o = tick_q;

endmodule

// File: rtl/frogger_hazard_ctrl.sv
// Scrolling obstacle lanes, frog collision detection and registered tile
// lookup feeding the frogger controller and renderer.
module frogger_hazard_ctrl
   import frogger_pkg::*;
#(
   parameter int unsigned c_TICK_BASE = 25000000,
   parameter int unsigned c_TICK_STEP = 150000,
   parameter int unsigned c_TICK_MIN  = 5000000,
   parameter int unsigned c_HIT_HOLD  = 4
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   frogger_hazard_ctrl_if.slave   bus
);

   localparam int HOLD_W = $clog2(c_HIT_HOLD + 1);

   hz_state_e         state_q;
   logic [HOLD_W-1:0] hold_q;
   logic              collided_q;
   logic [3:0]        tile_q, tile_d;
   logic [13:0]       lane_q [1:13];
   logic              tick;
   logic              moving;
   logic              frog_bit, qry_bit, hazard;

   assign moving = bus.i_Game_Active && (state_q != ST_IDLE);

   lane_tick_gen #(
      .c_TICK_BASE (c_TICK_BASE),
      .c_TICK_STEP (c_TICK_STEP),
      .c_TICK_MIN  (c_TICK_MIN)
   ) u_tick (
      .clk_i       (i_Clk),
      .rst_i       (i_Rst),
      .en_i        (moving),
      .score_i     (bus.i_Score),
      .tick_o      (tick),
      .lane_tick_o (bus.o_Lane_Tick)
   );

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         for (int r = 1; r <= 13; r++) lane_q[r] <= lane_init(4'(r));
      end else if (tick) begin
         for (int r = 1; r <= 13; r++) lane_q[r] <= rot_lane(4'(r), lane_q[r]);
      end
   end

   // Hazard sees the pre-rotation patterns when a tick lands on the same edge.
   always_comb begin
      frog_bit = 1'b0;
      if (bus.i_Frogger_Y >= RIVER_FIRST && bus.i_Frogger_Y <= ROAD_LAST &&
          bus.i_Frogger_X < NUM_COLS)
         frog_bit = lane_q[bus.i_Frogger_Y[3:0]][bus.i_Frogger_X[3:0]];
      hazard = (bus.i_Frogger_X < NUM_COLS) &&
               (((bus.i_Frogger_Y >= RIVER_FIRST && bus.i_Frogger_Y <= RIVER_LAST) && !frog_bit) ||
                ((bus.i_Frogger_Y >= ROAD_FIRST && bus.i_Frogger_Y <= ROAD_LAST) && frog_bit));
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q    <= ST_IDLE;
         hold_q     <= '0;
         collided_q <= 1'b0;
      end else begin
         collided_q <= 1'b0;
         if (!bus.i_Game_Active) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
         end else begin
            case (state_q)
               ST_IDLE: state_q <= ST_RUN;
               ST_RUN: begin
                  if (hazard) begin
                     collided_q <= 1'b1;
                     hold_q     <= '0;
                     state_q    <= ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  if (hold_q == HOLD_W'(c_HIT_HOLD - 1)) begin
                     hold_q  <= '0;
                     state_q <= ST_RUN;
                  end else begin
                     hold_q <= hold_q + 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      qry_bit = 1'b0;
      if (bus.i_Query_Row >= RIVER_FIRST && bus.i_Query_Row <= ROAD_LAST &&
          bus.i_Query_Col < NUM_COLS)
         qry_bit = lane_q[bus.i_Query_Row[3:0]][bus.i_Query_Col[3:0]];
      tile_d = TILE_ROAD;
      if (bus.i_Query_Col < NUM_COLS) begin
         if (bus.i_Query_Row == GOAL_ROW)
            tile_d = LILY_MASK[bus.i_Query_Col[3:0]] ? TILE_LILY : TILE_GRASS;
         else if (bus.i_Query_Row <= RIVER_LAST)
            tile_d = qry_bit ? TILE_LOG : TILE_WATER;
         else if (bus.i_Query_Row == MEDIAN_ROW || bus.i_Query_Row == START_ROW)
            tile_d = TILE_GRASS;
         else if (bus.i_Query_Row <= ROAD_LAST)
            tile_d = qry_bit ? TILE_CAR : TILE_ROAD;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) tile_q <= 4'd0;
      else       tile_q <= tile_d;
   end

   assign bus.o_Tile     = tile_q;
   assign bus.o_Collided = collided_q;

endmodule

// File: doc/frogger_hazard_ctrl.md
Name: frogger_hazard_ctrl

Overview:
- Upstream neighbour of the frogger controller: owns the scrolling obstacle lanes, produces the collision pulse and serves tile codes.
- Maintains one 14-bit occupancy pattern per hazard row and rotates it at a score-dependent rate.
- Checks the frog cell against the lane contents and drives the collision input of the frogger controller.
- Serves registered tile codes to the renderer and to the frogger controller's bitmap input.

Parameters:
- c_TICK_BASE, 25000000, lane-shift period in clocks at score 0.
- c_TICK_STEP, 150000, period reduction per score point.
- c_TICK_MIN, 5000000, floor on the shift period.
- c_HIT_HOLD, 4, clocks collision detection stays masked after a hit.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous active-high reset
- i_Game_Active  in  1  lanes move and collisions are checked only when high
- i_Score  in  7  current score; sets lane speed
- i_Frogger_X  in  6  frog column, 0..13
- i_Frogger_Y  in  6  frog row, 0..14
- i_Query_Col  in  6  tile lookup column
- i_Query_Row  in  6  tile lookup row
- o_Tile  out  4  tile code at the query cell; 1-cycle latency
- o_Collided  out  1  one-clock pulse when the frog occupies a hazard
- o_Lane_Tick  out  1  one-clock pulse on each lane shift

Behaviour:
- Reset (async, i_Rst=1): state IDLE; all lane patterns load their package initial values; tick counter 0; o_Tile=0; o_Collided=0; o_Lane_Tick=0.
- Row map:
  - row 0 goal: lily pads at cols 1,4,7,10,13, grass elsewhere.
  - rows 1-6 river: pattern bit=1 is log, 0 is water.
  - row 7 median: grass.
  - rows 8-13 road: bit=1 is car, 0 is road.
  - row 14 start: grass.
  - rows/cols out of range: tile 0.
- Tile codes: 0 road, 1 car, 2 water, 3 log, 4 lily pad, 5 grass.
- Period: P = c_TICK_BASE - i_Score*c_TICK_STEP, computed in 32 bits unsigned; if the subtraction underflows or P < c_TICK_MIN, P = c_TICK_MIN.
- Tick counter:
  - counts 0..P-1 while in RUN or HOLD.
  - on reaching P-1: wraps to 0, asserts o_Lane_Tick for 1 clock, and rotates every lane once.
  - a score change mid-count takes effect at the next compare; if the count is already >= the new P-1, the tick fires on the next clock.
- Rotation direction:
  - even rows rotate left: p <= {p[12:0],p[13]}.
  - odd rows rotate right: p <= {p[0],p[13:1]}.
- FSM states IDLE, RUN, HOLD.
  - IDLE: counter held at 0, no rotation, o_Collided=0. Go to RUN when i_Game_Active=1.
  - RUN: hazard check every clock against the current (pre-rotation) patterns.
    - hazard = (row 1-6 and bit=0) or (row 8-13 and bit=1).
    - on hazard: o_Collided=1 for exactly one clock, then go to HOLD.
  - HOLD: o_Collided=0; a counter runs c_HIT_HOLD clocks, then returns to RUN; lanes keep shifting.
  - Any state, i_Game_Active=0: next state IDLE, hold counter cleared, patterns keep their current values.
- Same-clock tick and hazard: the hazard is evaluated on the old pattern. The new pattern is visible to the check on the next clock.
- o_Tile: registered lookup of the current patterns at (i_Query_Row, i_Query_Col). It is valid in every state, including IDLE and during reset release.
- No combinational path from any input to o_Collided or o_Tile.

Decomposition:
- Package frogger_pkg holds:
  - tile code constants (TILE_ROAD..TILE_GRASS).
  - row boundaries (RIVER_FIRST=1, RIVER_LAST=6, ROAD_FIRST=8, ROAD_LAST=13, START_ROW=14).
  - NUM_COLS=14.
  - the 13 initial lane patterns.
  - the lily-pad column mask 14'b10010010010010.
- One sub-module, lane_tick_gen: period computation, saturation, tick counter and o_Lane_Tick. Lane storage, FSM and lookup stay in the top.

Test Plan (bench overrides c_TICK_BASE=8, c_TICK_STEP=1, c_TICK_MIN=2, c_HIT_HOLD=4):
- Reset mid-run with i_Rst=1 for 3 clocks -> all outputs 0 and the row-8 pattern equals its package initial value on the same edge.
- Game active, score 0 -> o_Lane_Tick pulses every 8 clocks. Row 8 pattern 14'b00000000000011 becomes 14'b00000000000110 after one tick; row 9 becomes 14'b10000000000001.
- Score 10 -> period saturates at 2, so a tick fires every 2 clocks. Score 3 -> period 5.
- Frog at (X=0, Y=8) with a car at col 0:
  - o_Collided is high for exactly 1 clock.
  - no further pulse for 4 clocks while the car remains.
  - a second pulse comes on clock 6.
- Frog on row 3:
  - log bit set -> no collision.
  - after a tick shifts water under the frog -> pulse on the next clock.
- Query (row 0, col 4) -> o_Tile=4 one clock later. Query (row 7, col 2) -> 5. Query (row 15, col 0) -> 0.
- Deassert i_Game_Active during HOLD -> IDLE, counters frozen. Reassert -> lanes resume from the frozen patterns.
